event_latency_tracker: RTL and testbench

Parametrised successor to the single-ID event timestamper. It tracks up to 2**ID_W concurrent events keyed by ID and timestamps each start and end against a free-running counter. Every completed event, orphan end or timed-out start becomes a status-tagged record in an internal output FIFO. It sits between the packet-event taps and the record sink, and absorbs sink backpressure up to OUT_DEPTH records.

---
 rtl/event_ts_pkg.sv | 12 +
 rtl/ts_record_fifo.sv | 75 +++++++
 rtl/event_latency_tracker.sv | 191 +++++++++++++++++++
 tb/tb_event_latency_tracker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_ts_pkg.sv
// Shared record status encoding for the event latency tracker.
package event_ts_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK      = 2'd0,
    ST_ORPHAN  = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_e;

endpackage

// File: rtl/ts_record_fifo.sv
// Show-ahead record FIFO: rd_data presents the head entry whenever rd_valid is high
// and reads back as zero when empty.
module ts_record_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;
  logic             pop_s;

  // Handshake qualification; a push into a full FIFO is only allowed alongside a pop.
  always_comb begin
    pop_s  = rd_en && (count_r != CNT_ZERO);
    push_s = wr_en && ((count_r != CNT_FULL) || pop_s);
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation, forced to zero while empty so reset leaves clean outputs.
  always_comb begin
    rd_valid = (count_r != CNT_ZERO);
    count    = count_r;
    if (rd_valid) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/event_latency_tracker.sv
// Multi-ID event latency tracker: timestamps starts/ends per ID against a free-running
// counter, sweeps for timed-out starts and queues status-tagged records for the sink.
module event_latency_tracker
  import event_ts_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int TS_W      = 64,
  parameter int OUT_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [ID_W-1:0]     start_id,
  input  logic                end_valid,
  output logic                end_ready,
  input  logic [ID_W-1:0]     end_id,
  input  logic                cfg_timeout_en,
  input  logic [TS_W-1:0]     cfg_timeout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_W-1:0]     out_id,
  output logic [STATUS_W-1:0] out_status,
  output logic [TS_W-1:0]     out_start_ts,
  output logic [TS_W-1:0]     out_end_ts,
  output logic [TS_W-1:0]     out_delta,
  output logic [ID_W:0]       inflight
);

  localparam int N_ID  = 2 ** ID_W;
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int REC_W = ID_W + STATUS_W + 3 * TS_W;

  localparam logic [TS_W-1:0]  TS_ZERO   = {TS_W{1'b0}};
  localparam logic [TS_W-1:0]  TS_ONE    = TS_W'(1);
  localparam logic [ID_W-1:0]  ID_ONE    = ID_W'(1);
  localparam logic [ID_W:0]    INF_ONE   = (ID_W+1)'(1);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W+1)'(OUT_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0] id;
    status_e         status;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] end_ts;
    logic [TS_W-1:0] delta;
  } record_t;

  logic [TS_W-1:0]  cnt_r;
  logic [N_ID-1:0]  active_r;
  logic [N_ID-1:0]  active_nx_s;
  logic [TS_W-1:0]  start_ts_r [N_ID];
  logic [ID_W-1:0]  sp_r;
  logic [ID_W:0]    inflight_r;
  logic             stage_valid_r;
  record_t          stage_rec_r;
  record_t          stage_rec_s;
  record_t          head_rec_s;
  logic [REC_W-1:0] head_vec_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [CNT_W:0]   fill_sum_s;
  logic             space_s;
  logic             end_fire_s;
  logic             end_hit_s;
  logic             start_fire_s;
  logic             sweep_fire_s;
  logic             to_cond_s;
  logic             clear_s;
  logic [TS_W-1:0]  age_s;
  logic [TS_W-1:0]  end_start_ts_s;

  // Handshakes and sweeper decision. Space ignores a same-cycle pop on purpose.
  always_comb begin
    fill_sum_s     = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, stage_valid_r};
    space_s        = (fill_sum_s < DEPTH_LIM);
    end_ready      = space_s;
    end_fire_s     = end_valid && space_s;
    end_hit_s      = active_r[end_id];
    end_start_ts_s = start_ts_r[end_id];
    start_ready    = !active_r[start_id] && !(end_fire_s && (end_id == start_id));
    start_fire_s   = start_valid && start_ready;
    age_s          = cnt_r - start_ts_r[sp_r];
    to_cond_s      = cfg_timeout_en && (cfg_timeout != TS_ZERO) && active_r[sp_r] &&
                     (age_s >= cfg_timeout);
    sweep_fire_s   = to_cond_s && !end_fire_s && space_s;
    clear_s        = (end_fire_s && end_hit_s) || sweep_fire_s;
  end

  // Next active-bit image; start and clear never target the same ID in one cycle.
  always_comb begin
    active_nx_s = active_r;
    if (start_fire_s) begin
      active_nx_s[start_id] = 1'b1;
    end else begin
      active_nx_s = active_nx_s;
    end
    if (end_fire_s && end_hit_s) begin
      active_nx_s[end_id] = 1'b0;
    end else if (sweep_fire_s) begin
      active_nx_s[sp_r] = 1'b0;
    end else begin
      active_nx_s = active_nx_s;
    end
  end

  // Record assembly; an end always wins the stage over a sweep.
  always_comb begin
    stage_rec_s = {REC_W{1'b0}};
    if (end_fire_s) begin
      stage_rec_s.id     = end_id;
      stage_rec_s.end_ts = cnt_r;
      if (end_hit_s) begin
        stage_rec_s.status   = ST_OK;
        stage_rec_s.start_ts = end_start_ts_s;
        stage_rec_s.delta    = cnt_r - end_start_ts_s;
      end else begin
        stage_rec_s.status   = ST_ORPHAN;
        stage_rec_s.start_ts = TS_ZERO;
        stage_rec_s.delta    = TS_ZERO;
      end
    end else if (sweep_fire_s) begin
      stage_rec_s.id       = sp_r;
      stage_rec_s.status   = ST_TIMEOUT;
      stage_rec_s.start_ts = start_ts_r[sp_r];
      stage_rec_s.end_ts   = cnt_r;
      stage_rec_s.delta    = age_s;
    end else begin
      stage_rec_s = stage_rec_r;
    end
  end

  // Start timestamp memory, intentionally not reset.
  always_ff @(posedge clk) begin
    if (start_fire_s) begin
      start_ts_r[start_id] <= cnt_r;
    end
  end

  // Counter, scoreboard bits, sweep pointer, inflight count and record stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= TS_ZERO;
      active_r      <= {N_ID{1'b0}};
      sp_r          <= {ID_W{1'b0}};
      inflight_r    <= {(ID_W+1){1'b0}};
      stage_valid_r <= 1'b0;
      stage_rec_r   <= {REC_W{1'b0}};
    end else begin
      cnt_r         <= cnt_r + TS_ONE;
      active_r      <= active_nx_s;
      stage_valid_r <= end_fire_s || sweep_fire_s;
      stage_rec_r   <= stage_rec_s;
      // Hold the pointer on an expired ID until its record can be emitted.
      if (to_cond_s && !sweep_fire_s) begin
        sp_r <= sp_r;
      end else begin
        sp_r <= sp_r + ID_ONE;
      end
      case ({start_fire_s, clear_s})
        2'b10:   inflight_r <= inflight_r + INF_ONE;
        2'b01:   inflight_r <= inflight_r - INF_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  ts_record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (stage_valid_r),
    .wr_data  (stage_rec_r),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  (head_vec_s),
    .count    (fifo_count_s)
  );

  // Unpack the FIFO head onto the record ports.
  always_comb begin
    head_rec_s   = head_vec_s;
    out_id       = head_rec_s.id;
    out_status   = head_rec_s.status;
    out_start_ts = head_rec_s.start_ts;
    out_end_ts   = head_rec_s.end_ts;
    out_delta    = head_rec_s.delta;
    inflight     = inflight_r;
  end

endmodule

// File: tb/tb_event_latency_tracker.sv
// Scoreboard bench for event_latency_tracker (ID_W=4, TS_W=8 to reach counter wrap).
module tb_event_latency_tracker;

  localparam int ID_W = 4;
  localparam int TS_W = 8;
  localparam int OUT_DEPTH = 8;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      status;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] end_ts;
    logic [TS_W-1:0] delta;
    bit              is_to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_valid = 1'b0;
  logic start_ready;
  logic [ID_W-1:0] start_id = '0;
  logic end_valid = 1'b0;
  logic end_ready;
  logic [ID_W-1:0] end_id = '0;
  logic cfg_timeout_en = 1'b0;
  logic [TS_W-1:0] cfg_timeout = 8'd20;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [ID_W-1:0] out_id;
  logic [1:0] out_status;
  logic [TS_W-1:0] out_start_ts;
  logic [TS_W-1:0] out_end_ts;
  logic [TS_W-1:0] out_delta;
  logic [ID_W:0] inflight;

  int chk_cnt = 0;
  int err_cnt = 0;
  int rec_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [TS_W-1:0] mon_d;
  logic [TS_W-1:0] tb_cnt;
  logic [TS_W-1:0] st_ts [16];

  event_latency_tracker #(
    .ID_W(ID_W), .TS_W(TS_W), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_id(start_id),
    .end_valid(end_valid), .end_ready(end_ready), .end_id(end_id),
    .cfg_timeout_en(cfg_timeout_en), .cfg_timeout(cfg_timeout),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_status(out_status), .out_start_ts(out_start_ts), .out_end_ts(out_end_ts),
    .out_delta(out_delta), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Reference cycle count: the value the DUT should stamp in the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 8'd0;
    else        tb_cnt <= tb_cnt + 8'd1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sink monitor: every accepted record is popped against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      rec_cnt++;
      check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_val("rec_id", 64'(out_id), 64'(mon_e.id));
        check_val("rec_status", 64'(out_status), 64'(mon_e.status));
        check_val("rec_start", 64'(out_start_ts), 64'(mon_e.start_ts));
        if (mon_e.is_to) begin
          mon_d = out_end_ts - mon_e.start_ts;
          check_val("to_delta", 64'(out_delta), 64'(mon_d));
          check_val("to_delta_range", 64'((mon_d >= 8'd20) && (mon_d <= 8'd37)), 64'd1);
        end else begin
          check_val("rec_end", 64'(out_end_ts), 64'(mon_e.end_ts));
          check_val("rec_delta", 64'(out_delta), 64'(mon_e.delta));
        end
      end
    end
  end

  function automatic exp_t mk(input logic [ID_W-1:0] id, input logic [1:0] st,
                              input logic [TS_W-1:0] s, input logic [TS_W-1:0] e,
                              input logic [TS_W-1:0] d, input bit to);
    exp_t r;
    r.id = id; r.status = st; r.start_ts = s; r.end_ts = e; r.delta = d; r.is_to = to;
    return r;
  endfunction

  // All drive tasks start and end at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; start_valid = 1'b0; end_valid = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_cnt(input logic [TS_W-1:0] t);
    int n = 0;
    while (tb_cnt != t && n < 300) begin @(negedge clk); n++; end
    check_val("wait_cnt", 64'(tb_cnt), 64'(t));
  endtask

  task automatic do_start(input logic [ID_W-1:0] id);
    int n = 0;
    start_valid = 1'b1; start_id = id; #1;
    while (!start_ready && n < 50) begin @(negedge clk); #1; n++; end
    check_val("start_accept", 64'(start_ready), 64'd1);
    st_ts[id] = tb_cnt;
    @(posedge clk); #1; start_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_end(input logic [ID_W-1:0] id, input bit hit);
    int n = 0;
    end_valid = 1'b1; end_id = id; #1;
    while (!end_ready && n < 50) begin @(negedge clk); #1; n++; end
    check_val("end_accept", 64'(end_ready), 64'd1);
    if (hit) sb.push_back(mk(id, 2'd0, st_ts[id], tb_cnt, tb_cnt - st_ts[id], 1'b0));
    else     sb.push_back(mk(id, 2'd1, 8'd0, tb_cnt, 8'd0, 1'b0));
    @(posedge clk); #1; end_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check_val("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc;
    int n;
    int rec0;
    do_reset();
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_inflight", 64'(inflight), 64'd0);
    check_val("rst_out_id", 64'(out_id), 64'd0);
    check_val("rst_start_ready", 64'(start_ready), 64'd1);
    check_val("rst_end_ready", 64'(end_ready), 64'd1);
    @(negedge clk);

    // Basic OK with latency check.
    wait_cnt(8'd10);
    do_start(4'd3);
    check_val("inflight_one", 64'(inflight), 64'd1);
    wait_cnt(8'd25);
    do_end(4'd3, 1'b1);
    #1;
    check_val("lat_n1_invalid", 64'(out_valid), 64'd0);
    @(negedge clk); #1;
    check_val("lat_n2_valid", 64'(out_valid), 64'd1);
    check_val("basic_delta", 64'(out_delta), 64'd15);
    @(negedge clk);
    drain(10);

    // Orphan leaves inflight alone.
    do_start(4'd1);
    wait_cnt(8'd40);
    do_end(4'd7, 1'b0);
    check_val("orphan_inflight", 64'(inflight), 64'd1);
    drain(10);

    // Same-cycle start/end hazard on ID 5.
    do_start(4'd5);
    start_valid = 1'b1; start_id = 4'd5; end_valid = 1'b1; end_id = 4'd5; #1;
    check_val("hz_start_blocked", 64'(start_ready), 64'd0);
    check_val("hz_end_ready", 64'(end_ready), 64'd1);
    sb.push_back(mk(4'd5, 2'd0, st_ts[5], tb_cnt, tb_cnt - st_ts[5], 1'b0));
    @(posedge clk); #1; end_valid = 1'b0;
    @(negedge clk); #1;
    check_val("hz_start_next", 64'(start_ready), 64'd1);
    st_ts[5] = tb_cnt;
    @(posedge clk); #1; start_valid = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    do_end(4'd5, 1'b1);
    do_end(4'd1, 1'b1);
    drain(10);
    check_val("hz_inflight", 64'(inflight), 64'd0);

    // Timeout sweep, then a late end is an orphan.
    do_reset();
    cfg_timeout = 8'd20; cfg_timeout_en = 1'b1;
    wait_cnt(8'd5);
    do_start(4'd2);
    sb.push_back(mk(4'd2, 2'd2, 8'd5, 8'd0, 8'd0, 1'b1));
    drain(60);
    check_val("to_inflight", 64'(inflight), 64'd0);
    do_end(4'd2, 1'b0);
    drain(10);
    cfg_timeout_en = 1'b0;

    // Backpressure: exactly OUT_DEPTH ends accepted, starts still allowed.
    do_reset();
    out_ready = 1'b0;
    acc = 0; n = 0;
    while (acc < 10 && n < 30) begin
      end_valid = 1'b1; end_id = 4'(acc); #1;
      if (end_ready) begin
        sb.push_back(mk(4'(acc), 2'd1, 8'd0, tb_cnt, 8'd0, 1'b0));
        acc++;
      end
      @(negedge clk); n++;
    end
    end_valid = 1'b0; #1;
    check_val("bp_accepted", 64'(acc), 64'd8);
    check_val("bp_end_ready_low", 64'(end_ready), 64'd0);
    @(negedge clk);
    do_start(4'd12);
    check_val("bp_start_inflight", 64'(inflight), 64'd1);
    rec0 = rec_cnt;
    out_ready = 1'b1;
    drain(40);
    check_val("bp_rec_count", 64'(rec_cnt - rec0), 64'd8);

    // Counter wrap, then asynchronous reset mid-burst.
    do_reset();
    wait_cnt(8'd250);
    do_start(4'd9);
    wait_cnt(8'd4);
    do_end(4'd9, 1'b1);
    #1;
    check_val("wrap_model_delta", 64'(sb[0].delta), 64'd10);
    @(negedge clk);
    drain(10);
    out_ready = 1'b0;
    do_start(4'd0);
    do_start(4'd1);
    do_end(4'd0, 1'b1);
    do_end(4'd4, 1'b0);
    @(negedge clk); #1;
    check_val("pre_rst_valid", 64'(out_valid), 64'd1);
    check_val("pre_rst_inflight", 64'(inflight), 64'd1);
    #1; rst_n = 1'b0; #1;
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_inflight", 64'(inflight), 64'd0);
    check_val("arst_out_id", 64'(out_id), 64'd0);
    check_val("arst_out_status", 64'(out_status), 64'd0);
    check_val("arst_out_start", 64'(out_start_ts), 64'd0);
    check_val("arst_out_end", 64'(out_end_ts), 64'd0);
    check_val("arst_out_delta", 64'(out_delta), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check_val("post_rst_empty", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
